mux_scan_ctrl: RTL and testbench
================================

// Module: mux_scan_ctrl
// PURPOSE
//   Sequencer that sits directly upstream of the 8:1 x 4-bit word mux (mux8b).
//   - Drives the mux select through channels 0..7, one channel at a time.
//   - Reads back the mux output for each channel.
//   - Reduces the masked channels to a sum or a maximum and reports it with a
//     start/busy/done handshake.
//   - The mux is combinational; sel and mux_data close a loop through it inside
//     one clock period.
// PARAMETERS
//   SETTLE  0  extra cycles sel is held on each channel before sampling (0..15)
// PORTS
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous, active-high reset
//   start     in   1  begin a scan; sampled only in IDLE
//   mask      in   8  channel include mask, bit k = channel k; latched on start
//   mode      in   1  0 = sum, 1 = max; latched on start
//   mux_data  in   4  mux output for the channel currently on sel
//   sel       out  3  mux select (mux ctrl), registered
//   busy      out  1  high while a scan is in progress
//   done      out  1  one-cycle pulse; result, max_idx and count are valid
//   result    out  7  sum (0..120), or max value zero-extended, per mode
//   max_idx   out  3  lowest channel index holding the max (both modes)
//   count     out  4  number of channels included (popcount of latched mask)
// BEHAVIOUR
//   Reset values: sel=0, busy=0, done=0, result=0, max_idx=0, count=0, FSM=IDLE.
//   rst has priority over every other input.
//   FSM states: IDLE, SCAN, DONE.
//   - IDLE
//     - start=1 -> latch mask and mode, clear the accumulators, set sel=0,
//       busy=1, clear the dwell counter, go to SCAN.
//     - result, max_idx and count hold their previous values until this edge.
//   - SCAN
//     - sel=k is held for SETTLE+1 cycles.
//     - mux_data is sampled on the last edge of that window.
//     - If mask_q[k]=1: sum += mux_data; count += 1.
//       If mux_data > cur_max (strict), cur_max and max_idx update to k.
//       Equal values therefore keep the lower index.
//     - If mask_q[k]=0, the channel is still dwelt on for the full window but is
//       not accumulated.
//     - After sampling k=7: write result and count, sel=0, busy=0, done=1,
//       go to DONE.
//   - DONE
//     - done=1 for exactly this one cycle; next edge -> IDLE, done=0.
//     - start is ignored here.
//     - start held high continuously restarts one cycle later, from IDLE.
//   start is ignored while busy.
//   Latency: done rises on edge 8*(SETTLE+1) after the edge that accepted start.
//   Total scan time is independent of mask.
//   Width rules:
//   - sum accumulator is 7 bits; maximum 8*15 = 120, so it never wraps.
//   - count is 4 bits (0..8).
//   - dwell counter is 4 bits.
//   mask=0: full-length scan, result=0, count=0, max_idx=0.
//   Max mode with all included channels = 0: result=0, max_idx=0.
//   Reset mid-scan: next edge gives reset values, with no done pulse and no
//   partial result.
// TESTING
//   1. SETTLE=0, mux w1..w8=1..8, mask=FF, mode=0, start for 1 cycle
//      -> sel steps 0..7 on consecutive cycles; done 8 edges after accept;
//      result=36, count=8, max_idx=7.
//   2. Same data, mode=1, mask=8'b0010_0110
//      -> result=6, max_idx=5, count=3.
//   3. All words=15, mode=1, mask=FF -> result=15, max_idx=0 (tie takes the
//      lowest index); mode=0 -> result=120, no wrap.
//   4. SETTLE=2, mask=00 -> each sel value held 3 cycles; done 24 edges after
//      accept; result=0, count=0; start pulsed mid-scan has no effect.
//   5. rst asserted on the 4th SCAN cycle -> next edge gives sel=0, busy=0,
//      done=0, result=0; a following start runs a clean full scan.
//   6. start held high across two scans -> done pulses twice, 10 edges apart
//      (SETTLE=0); each pulse lasts exactly one cycle.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer driving the select of a combinational 8:1 x 4-bit
// word mux. It steps sel through channels 0..7 and dwells SETTLE+1 cycles on
// each one. On the last cycle of each dwell it samples the mux output. The
// masked channels are reduced to a sum (mode=0) or a maximum (mode=1), and the
// reduction is reported with a start/busy/done handshake.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     begin a scan (accepted only in IDLE)
//   mask[7:0] channel include mask, latched on start
//   mode      0 = sum, 1 = max, latched on start
//   mux_data  mux output for the channel currently on sel
//   sel[2:0]  registered mux select
//   busy      scan in progress
//   done      one-cycle pulse: result/max_idx/count valid
//   result    sum (0..120) or zero-extended max
//   max_idx   lowest included channel index holding the max
//   count     number of included channels
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mask,
  input  logic       mode,
  input  logic [3:0] mux_data,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [6:0] result,
  output logic [2:0] max_idx,
  output logic [3:0] count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [3:0] DWELL_LAST = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] dwell_q, dwell_d;
  logic [7:0] mask_q, mask_d;
  logic       mode_q, mode_d;
  logic [6:0] sum_q, sum_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] max_q, max_d;
  logic [2:0] midx_q, midx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [6:0] result_q, result_d;
  logic [2:0] max_idx_q, max_idx_d;
  logic [3:0] count_q, count_d;

  // Accumulator values after folding in the channel currently on sel.
  logic       incl;
  logic [6:0] nsum;
  logic [3:0] ncnt;
  logic [3:0] nmax;
  logic [2:0] nidx;

  always_comb begin
    incl = mask_q[sel_q];
    nsum = sum_q + (incl ? {3'b000, mux_data} : 7'd0);
    ncnt = cnt_q + {3'b000, incl};
    nmax = max_q;
    nidx = midx_q;
    // Strict compare keeps the lower index on ties.
    if (incl && (mux_data > max_q)) begin
      nmax = mux_data;
      nidx = sel_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dwell_d   = dwell_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    midx_d    = midx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    result_d  = result_q;
    max_idx_d = max_idx_q;
    count_d   = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = mask;
          mode_d  = mode;
          sum_d   = '0;
          cnt_d   = '0;
          max_d   = '0;
          midx_d  = '0;
          sel_d   = '0;
          dwell_d = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 4'd1;
        end else begin
          dwell_d = '0;
          sum_d   = nsum;
          cnt_d   = ncnt;
          max_d   = nmax;
          midx_d  = nidx;
          if (sel_q == 3'd7) begin
            result_d  = mode_q ? {3'b000, nmax} : nsum;
            max_idx_d = nidx;
            count_d   = ncnt;
            sel_d     = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      dwell_q   <= '0;
      mask_q    <= '0;
      mode_q    <= 1'b0;
      sum_q     <= '0;
      cnt_q     <= '0;
      max_q     <= '0;
      midx_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      dwell_q   <= dwell_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      midx_q    <= midx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      max_idx_q <= max_idx_d;
      count_q   <= count_d;
    end
  end

  assign sel     = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign max_idx = max_idx_q;
  assign count   = count_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two instances: SETTLE=0 (index 0) and SETTLE=2 (index 1).
  logic        rst0, start0, mode0, rst2, start2, mode2;
  logic [7:0]  mask0, mask2;
  logic [31:0] wd0, wd2;
  logic [3:0]  md0, md2;
  logic [2:0]  sel0, sel2, idx0, idx2;
  logic        busy0, busy2, done0, done2;
  logic [6:0]  res0, res2;
  logic [3:0]  cnt0, cnt2;

  // Behavioural mux8b: word k lives in nibble k.
  assign md0 = wd0[{sel0, 2'b00} +: 4];
  assign md2 = wd2[{sel2, 2'b00} +: 4];

  mux_scan_ctrl #(.SETTLE(0)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .mask(mask0), .mode(mode0),
    .mux_data(md0), .sel(sel0), .busy(busy0), .done(done0),
    .result(res0), .max_idx(idx0), .count(cnt0));

  mux_scan_ctrl #(.SETTLE(2)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .mask(mask2), .mode(mode2),
    .mux_data(md2), .sel(sel2), .busy(busy2), .done(done2),
    .result(res2), .max_idx(idx2), .count(cnt2));

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          w;
    logic [31:0] wds;
    logic [7:0]  m;
    logic        md;
    int          pulse;
    int          er, ei, ec;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drv(input int w, input logic st, input logic [7:0] m, input logic md);
    if (w == 0) begin start0 = st; mask0 = m; mode0 = md; end
    else        begin start2 = st; mask2 = m; mode2 = md; end
  endtask

  task automatic rd(input int w, output logic [2:0] s, output logic b, output logic d,
                    output logic [6:0] r, output logic [2:0] ix, output logic [3:0] c);
    if (w == 0) begin s = sel0; b = busy0; d = done0; r = res0; ix = idx0; c = cnt0; end
    else        begin s = sel2; b = busy2; d = done2; r = res2; ix = idx2; c = cnt2; end
  endtask

  // Reference: sum / max / popcount straight from the channel words.
  task automatic model(input logic [31:0] wds, input logic [7:0] m, input logic md,
                       output int r, output int ix, output int c);
    int sum, mx, v;
    sum = 0; mx = 0; c = 0; ix = 0;
    for (int k = 0; k < 8; k++) begin
      v = int'(wds[k*4 +: 4]);
      if (m[k]) begin
        c++;
        sum += v;
        if (v > mx) mx = v;
      end
    end
    if (mx > 0) begin
      for (int k = 7; k >= 0; k--)
        if (m[k] && int'(wds[k*4 +: 4]) == mx) ix = k;
    end
    r = md ? mx : sum;
  endtask

  task automatic run_scan(input int w, input logic [31:0] wds, input logic [7:0] m,
                          input logic md, input int pulse_at,
                          input int er, input int ei, input int ec, input string nm);
    int s, lat, n, hit;
    logic [2:0] sl, ix;
    logic b, d;
    logic [6:0] r;
    logic [3:0] c;
    s = (w == 0) ? 0 : 2;
    lat = 8 * (s + 1);
    if (w == 0) wd0 = wds; else wd2 = wds;
    drv(w, 1'b1, m, md);
    @(posedge clk); #1;
    drv(w, 1'b0, ~m, ~md);
    rd(w, sl, b, d, r, ix, c);
    chk({nm, " accept busy"}, int'(b), 1);
    chk({nm, " accept sel"}, int'(sl), 0);
    hit = 0;
    n = 0;
    while (hit == 0 && n < lat + 4) begin
      @(posedge clk); #1;
      n++;
      rd(w, sl, b, d, r, ix, c);
      if (d) begin
        hit = n;
      end else if (n < lat) begin
        chk({nm, " sel step"}, int'(sl), n / (s + 1));
        chk({nm, " busy"}, int'(b), 1);
      end
      if (n == pulse_at) drv(w, 1'b1, 8'hFF, ~md);
      else               drv(w, 1'b0, ~m, ~md);
    end
    if (hit == 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: no done within %0d edges, required %0d", nm, lat + 4, lat);
    end else begin
      chk({nm, " latency"}, hit, lat);
      chk({nm, " result"}, int'(r), er);
      chk({nm, " max_idx"}, int'(ix), ei);
      chk({nm, " count"}, int'(c), ec);
      chk({nm, " done sel"}, int'(sl), 0);
      chk({nm, " done busy"}, int'(b), 0);
      @(posedge clk); #1;
      rd(w, sl, b, d, r, ix, c);
      chk({nm, " done width"}, int'(d), 0);
      chk({nm, " result hold"}, int'(r), er);
    end
  endtask

  initial begin
    logic [2:0] sl, ix;
    logic b, d;
    logic [6:0] r;
    logic [3:0] c;
    int er, ei, ec, np, t1, t2, after;
    logic [31:0] rw;
    logic [7:0] rm;
    logic rmd;
    logic hist[1:40];

    tbl[0] = '{0, 32'h87654321, 8'hFF, 1'b0, 0, 36, 7, 8};
    tbl[1] = '{0, 32'h87654321, 8'b0010_0110, 1'b1, 0, 6, 5, 3};
    tbl[2] = '{0, 32'hFFFFFFFF, 8'hFF, 1'b1, 0, 15, 0, 8};
    tbl[3] = '{0, 32'hFFFFFFFF, 8'hFF, 1'b0, 0, 120, 0, 8};
    tbl[4] = '{1, 32'h87654321, 8'h00, 1'b0, 5, 0, 0, 0};
    tbl[5] = '{0, 32'h87650021, 8'h0C, 1'b1, 0, 0, 0, 2};
    tbl[6] = '{1, 32'h19119111, 8'hFF, 1'b1, 0, 9, 3, 8};

    rst0 = 1'b1; rst2 = 1'b1;
    drv(0, 1'b0, 8'h00, 1'b0);
    drv(1, 1'b0, 8'h00, 1'b0);
    wd0 = '0; wd2 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      rd(w, sl, b, d, r, ix, c);
      chk("reset sel", int'(sl), 0);
      chk("reset busy", int'(b), 0);
      chk("reset done", int'(d), 0);
      chk("reset result", int'(r), 0);
      chk("reset max_idx", int'(ix), 0);
      chk("reset count", int'(c), 0);
    end
    rst0 = 1'b0; rst2 = 1'b0;

    for (int i = 0; i < 7; i++)
      run_scan(tbl[i].w, tbl[i].wds, tbl[i].m, tbl[i].md, tbl[i].pulse,
               tbl[i].er, tbl[i].ei, tbl[i].ec, $sformatf("vec%0d", i));

    // Reset during the 4th SCAN cycle: no done, no partial result.
    wd0 = 32'h87654321;
    drv(0, 1'b1, 8'hFF, 1'b0);
    @(posedge clk); #1;
    drv(0, 1'b0, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    rd(0, sl, b, d, r, ix, c);
    chk("midrst sel", int'(sl), 0);
    chk("midrst busy", int'(b), 0);
    chk("midrst done", int'(d), 0);
    chk("midrst result", int'(r), 0);
    chk("midrst max_idx", int'(ix), 0);
    chk("midrst count", int'(c), 0);
    np = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done0 || busy0) np++;
    end
    chk("midrst quiet", np, 0);
    run_scan(0, 32'h87654321, 8'hFF, 1'b0, 0, 36, 7, 8, "postrst");

    // start held high across two scans.
    wd0 = 32'h87654321;
    drv(0, 1'b1, 8'hFF, 1'b0);
    np = 0; t1 = 0; t2 = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      hist[e] = done0;
      if (done0) begin
        np++;
        if (np == 1) t1 = e;
        if (np == 2) begin t2 = e; drv(0, 1'b0, 8'hFF, 1'b0); end
        chk("hold result", int'(res0), 36);
      end
    end
    chk("hold pulses", np, 2);
    chk("hold first", t1, 9);
    chk("hold spacing", t2 - t1, 10);
    after = 0;
    if (t1 > 0 && t1 < 40 && hist[t1 + 1]) after++;
    if (t2 > 0 && t2 < 40 && hist[t2 + 1]) after++;
    chk("hold pulse width", after, 0);

    // Randomized scans checked against the reference model.
    for (int i = 0; i < 24; i++) begin
      rw  = $urandom;
      rm  = 8'($urandom);
      rmd = 1'($urandom_range(0, 1));
      if (i % 6 == 0) rm = 8'h00;
      if (i % 6 == 1) rw = rw & 32'h33333333;
      model(rw, rm, rmd, er, ei, ec);
      run_scan((i % 4 == 3) ? 1 : 0, rw, rm, rmd, 0, er, ei, ec, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

endmodule
